// File: rtl/sega_joy_scanner.sv
// Sega DB9 controller scanner.
// Drives the shared select line (pin 7) through a fixed per-frame step schedule and decodes
// Master System, Mega Drive 3-button and 6-button pads independently on each port.
// Each port's 12-bit MXYZ SACB RLDU word is assembled in shadow registers during the frame.
// All ports are then published together in one clock, marked by a frame_done_o strobe.
module sega_joy_scanner #(
   parameter int NUM_PORTS   = 2,
   parameter int STEP_DIV    = 1536,
   parameter int FRAME_STEPS = 256,
   parameter bit ACTIVE_HIGH = 1'b0
) (
   input  logic                     clk_i,
   input  logic                     res_n_i,
   input  logic                     enable_i,
   input  logic [NUM_PORTS*6-1:0]   joy_pins_i,
   output logic                     joy_p7_o,
   output logic [NUM_PORTS*12-1:0]  joy_o,
   output logic [NUM_PORTS-1:0]     six_btn_o,
   output logic [NUM_PORTS-1:0]     md_o,
   output logic                     frame_done_o
);

   localparam int DIV_W  = $clog2(STEP_DIV);
   localparam int STEP_W = $clog2(FRAME_STEPS);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAME_STEPS - 1);
   localparam logic [STEP_W-1:0] STEP_0    = STEP_W'(0);
   localparam logic [STEP_W-1:0] STEP_1    = STEP_W'(1);
   localparam logic [STEP_W-1:0] STEP_2    = STEP_W'(2);
   localparam logic [STEP_W-1:0] STEP_4    = STEP_W'(4);
   localparam logic [STEP_W-1:0] STEP_5    = STEP_W'(5);
   localparam logic [STEP_W-1:0] STEP_7    = STEP_W'(7);

   // Shadow words hold raw pin levels: 1 means released.
   localparam logic [11:0]              SHADOW_REL = 12'hFFF;
   localparam logic [NUM_PORTS*12-1:0]  JOY_REL    = ACTIVE_HIGH ? {(NUM_PORTS*12){1'b0}}
                                                                 : {(NUM_PORTS*12){1'b1}};

   // SCAN_RESET only exists between reset release and the first step decision; afterwards the
   // scanner is either running a frame or parked on the last step.
   typedef enum logic [0:0] {
      SCAN_RESET = 1'b0,
      SCAN_RUN   = 1'b1
   } scan_state_t;

   scan_state_t                   state_r, state_s;
   logic [NUM_PORTS*6-1:0]        pins_meta_r, pins_sync_r;
   logic [DIV_W-1:0]              div_r;
   logic [STEP_W-1:0]             step_r, step_s;
   logic                          step_end_s;
   logic                          p7_s, p7_r;
   logic [NUM_PORTS-1:0][11:0]    shadow_r;
   logic [NUM_PORTS-1:0]          md_sh_r, six_sh_r;
   logic                          commit_r, done_r;
   logic [NUM_PORTS*12-1:0]       joy_r;
   logic [NUM_PORTS-1:0]          six_r, md_r;

   // Map a pin-level word onto the published polarity.
   function automatic logic [11:0] to_out_pol(input logic [11:0] lvl);
      logic [11:0] res;
      if (ACTIVE_HIGH) begin
         res = ~lvl;
      end else begin
         res = lvl;
      end
      return res;
   endfunction

   assign step_end_s = (div_r == DIV_LAST);

   // Two-flop synchroniser on every raw pad pin.
   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         pins_meta_r <= {(NUM_PORTS*6){1'b1}};
         pins_sync_r <= {(NUM_PORTS*6){1'b1}};
      end else begin
         pins_meta_r <= joy_pins_i;
         pins_sync_r <= pins_meta_r;
      end
   end

   // Next step / state and the select level that goes with the next step.
   always_comb begin
      state_s = state_r;
      step_s  = step_r;
      p7_s    = 1'b1;
      if (step_end_s) begin
         if ((state_r == SCAN_RESET) || (step_r == STEP_LAST)) begin
            // Frame boundary: enable decides between a new frame and parking.
            state_s = SCAN_RUN;
            if (enable_i) begin
               step_s = STEP_0;
            end else begin
               step_s = STEP_LAST;
            end
         end else begin
            step_s = step_r + STEP_W'(1);
         end
      end else begin
         step_s = step_r;
      end
      // Even steps 0..6 pull select low; everything else, including park, keeps it high.
      if ((state_s == SCAN_RUN) && (step_s < STEP_7) && (step_s[0] == 1'b0)) begin
         p7_s = 1'b0;
      end else begin
         p7_s = 1'b1;
      end
   end

   // Step divider, scan state, step counter and registered select line.
   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         div_r   <= {DIV_W{1'b0}};
         state_r <= SCAN_RESET;
         step_r  <= STEP_0;
         p7_r    <= 1'b1;
      end else begin
         div_r   <= step_end_s ? {DIV_W{1'b0}} : (div_r + DIV_W'(1));
         state_r <= state_s;
         step_r  <= step_s;
         p7_r    <= p7_s;
      end
   end

   // End-of-step sampling into the per-port shadow registers.
   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         shadow_r <= {NUM_PORTS{SHADOW_REL}};
         md_sh_r  <= {NUM_PORTS{1'b0}};
         six_sh_r <= {NUM_PORTS{1'b0}};
      end else if (step_end_s && (state_r == SCAN_RUN)) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            case (step_r)
               STEP_1: begin
                  // {C,B,R,L,D,U} line up with {p9,p6,right,left,down,up}.
                  shadow_r[p][5:0] <= pins_sync_r[6*p +: 6];
               end
               STEP_2: begin
                  // A Mega Drive pad grounds left and right while select is low.
                  if ((pins_sync_r[6*p+3] == 1'b0) && (pins_sync_r[6*p+2] == 1'b0)) begin
                     md_sh_r[p]       <= 1'b1;
                     shadow_r[p][7:6] <= pins_sync_r[6*p+4 +: 2];
                  end else begin
                     md_sh_r[p]       <= 1'b0;
                     shadow_r[p][7:6] <= 2'b11;
                  end
               end
               STEP_4: begin
                  // Third low phase of a 6-button pad grounds all four directions.
                  six_sh_r[p] <= md_sh_r[p] && (pins_sync_r[6*p +: 4] == 4'b0000);
               end
               STEP_5: begin
                  if (six_sh_r[p]) begin
                     shadow_r[p][11:8] <= pins_sync_r[6*p +: 4];
                  end else begin
                     shadow_r[p][11:8] <= 4'hF;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Commit of all shadow words together, one clock after step 5 completes.
   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         commit_r <= 1'b0;
         done_r   <= 1'b0;
         joy_r    <= JOY_REL;
         six_r    <= {NUM_PORTS{1'b0}};
         md_r     <= {NUM_PORTS{1'b0}};
      end else begin
         commit_r <= step_end_s && (state_r == SCAN_RUN) && (step_r == STEP_5);
         done_r   <= commit_r;
         if (commit_r) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
               joy_r[12*p +: 12] <= to_out_pol(shadow_r[p]);
            end
            six_r <= six_sh_r;
            md_r  <= md_sh_r;
         end
      end
   end

   assign joy_p7_o     = p7_r;
   assign joy_o        = joy_r;
   assign six_btn_o    = six_r;
   assign md_o         = md_r;
   assign frame_done_o = done_r;

endmodule

// File: tb/tb_sega_joy_scanner.sv
// Directed bench for sega_joy_scanner (STEP_DIV=8, FRAME_STEPS=16, two ports, active-low out).
// Pad behaviour models drive the pins from the select line; expected words are hand-computed.
module tb_sega_joy_scanner;

   logic        clk = 1'b0;
   logic        res_n;
   logic        enable;
   logic [11:0] joy_pins;
   logic        joy_p7;
   logic [23:0] joy;
   logic [1:0]  six_btn;
   logic [1:0]  md;
   logic        frame_done;

   int          checks   = 0;
   int          failures = 0;

   // Pad models: type 0 Master System, 1 MD 3-button, 2 MD 6-button; btn bits = pressed, MXYZ SACB RLDU.
   int          ptype0 = 0;
   int          ptype1 = 0;
   logic [11:0] btn0 = 12'h000;
   logic [11:0] btn1 = 12'h000;
   int          low_cnt = 0;
   int          hi_cnt  = 0;
   logic        p7_d    = 1'b1;

   sega_joy_scanner #(
      .NUM_PORTS   (2),
      .STEP_DIV    (8),
      .FRAME_STEPS (16),
      .ACTIVE_HIGH (1'b0)
   ) dut (
      .clk_i        (clk),
      .res_n_i      (res_n),
      .enable_i     (enable),
      .joy_pins_i   (joy_pins),
      .joy_p7_o     (joy_p7),
      .joy_o        (joy),
      .six_btn_o    (six_btn),
      .md_o         (md),
      .frame_done_o (frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] pad_pins(input int ptype, input logic [11:0] btn,
                                           input logic p7, input int cnt);
      logic [11:0] n;
      logic [5:0]  r;
      n = ~btn;
      if (ptype == 0) begin
         r = {n[5], n[4], n[3:0]};
      end else if (p7) begin
         if (ptype == 2 && cnt == 3) r = {n[5], n[4], n[11:8]};
         else                        r = {n[5], n[4], n[3:0]};
      end else begin
         if (ptype == 2 && cnt == 3)      r = {n[7], n[6], 4'b0000};
         else if (ptype == 2 && cnt >= 4) r = {n[7], n[6], 4'b1111};
         else                             r = {n[7], n[6], 2'b00, n[1], n[0]};
      end
      return r;
   endfunction

   assign joy_pins = {pad_pins(ptype1, btn1, joy_p7, low_cnt),
                      pad_pins(ptype0, btn0, joy_p7, low_cnt)};

   // 6-button pad phase counter: counts select falls, clears after a long high idle.
   always @(posedge clk) begin
      p7_d <= joy_p7;
      if (p7_d && !joy_p7) low_cnt <= low_cnt + 1;
      else if (hi_cnt > 20) low_cnt <= 0;
      if (joy_p7) hi_cnt <= hi_cnt + 1;
      else        hi_cnt <= 0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for frame_done, sampling on negedges; lat = posedges until it was seen.
   task automatic wait_done(input string tag, input int bound, output int lat);
      logic found;
      found = 1'b0;
      lat   = 0;
      while (!found && lat < bound) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (frame_done) found = 1'b1;
      end
      checks++;
      assert (found === 1'b1) else begin
         failures++;
         $error("FAIL %s observed=no_done expected=done_within_%0d", tag, bound);
      end
   endtask

   initial begin
      int lat;
      int bad_p7;
      int bad_done;
      int t;
      int s;
      logic exp_p7;
      logic exp_done;

      // 1: reset held while pins toggle
      res_n  = 1'b0;
      enable = 1'b1;
      ptype0 = 2;
      ptype1 = 2;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         btn0 = ~btn0;
         btn1 = btn1 ^ 12'h0F0;
      end
      @(negedge clk);
      chk("rst_p7", {31'd0, joy_p7}, 32'd1);
      chk("rst_joy", {8'd0, joy}, 32'hFFFFFF);
      chk("rst_six", {30'd0, six_btn}, 32'd0);
      chk("rst_md", {30'd0, md}, 32'd0);
      chk("rst_done", {31'd0, frame_done}, 32'd0);

      // 2: Master System pad on port 0, B pressed; port 1 idle MS
      ptype0 = 0; btn0 = 12'h010;
      ptype1 = 0; btn1 = 12'h000;
      res_n  = 1'b1;
      wait_done("ms_done", 200, lat);
      chk("first_latency", lat, 32'd57);
      chk("ms_joy", {8'd0, joy}, 32'hFFFFEF);
      chk("ms_md", {30'd0, md}, 32'd0);
      chk("ms_six", {30'd0, six_btn}, 32'd0);

      // 3: 3-button pad on port 0, Start + Right
      ptype0 = 1; btn0 = 12'h088;
      wait_done("md3_done", 200, lat);
      chk("frame_period", lat, 32'd128);
      chk("md3_joy0", {20'd0, joy[11:0]}, 32'hF77);
      chk("md3_joy1", {20'd0, joy[23:12]}, 32'hFFF);
      chk("md3_md0", {31'd0, md[0]}, 32'd1);
      chk("md3_six0", {31'd0, six_btn[0]}, 32'd0);

      // 4: 6-button pad on port 1, X + A; port 0 idle MS
      ptype0 = 0; btn0 = 12'h000;
      ptype1 = 2; btn1 = 12'h440;
      wait_done("md6_done", 200, lat);
      chk("md6_joy", {8'd0, joy}, 32'hBBFFFF);
      chk("md6_six", {30'd0, six_btn}, 32'd2);
      chk("md6_md", {30'd0, md}, 32'd2);

      // Mixed: port 0 6-button (M,Z,S,Up), port 1 3-button (C,B,Left,Down)
      ptype0 = 2; btn0 = 12'h981;
      ptype1 = 1; btn1 = 12'h036;
      wait_done("mix_done", 200, lat);
      chk("mix_joy", {8'd0, joy}, 32'hFC967E);
      chk("mix_six", {30'd0, six_btn}, 32'd1);
      chk("mix_md", {30'd0, md}, 32'd3);

      // 5: select pattern and done pulse over one frame; c=0 is the clock done is high
      for (int c = 0; c <= 128; c++) begin
         t        = c + 1;
         s        = (6 + t / 8) % 16;
         exp_p7   = (s <= 6 && (s % 2) == 0) ? 1'b0 : 1'b1;
         exp_done = (c == 0 || c == 128) ? 1'b1 : 1'b0;
         chk($sformatf("p7_c%0d", c), {31'd0, joy_p7}, {31'd0, exp_p7});
         chk($sformatf("done_c%0d", c), {31'd0, frame_done}, {31'd0, exp_done});
         @(posedge clk);
         @(negedge clk);
      end

      // 6: disable mid-frame; current frame still commits
      ptype0 = 0; btn0 = 12'h020;
      repeat (95) @(negedge clk);
      enable = 1'b0;
      wait_done("dis_done", 200, lat);
      chk("dis_latency", lat, 32'd32);
      chk("dis_joy", {8'd0, joy}, 32'hFC9FDF);
      chk("dis_md", {30'd0, md}, 32'd2);
      chk("dis_six", {30'd0, six_btn}, 32'd0);
      btn0 = 12'h001;
      repeat (8) @(negedge clk);
      bad_p7   = 0;
      bad_done = 0;
      for (int i = 0; i < 300; i++) begin
         if (joy_p7 !== 1'b1) bad_p7++;
         if (frame_done !== 1'b0) bad_done++;
         @(negedge clk);
      end
      chk("park_p7_low", bad_p7, 32'd0);
      chk("park_done", bad_done, 32'd0);
      chk("park_hold", {8'd0, joy}, 32'hFC9FDF);

      enable = 1'b1;
      wait_done("reen_done", 200, lat);
      chk("reen_latency", {31'd0, (lat >= 50 && lat <= 57)}, 32'd1);
      chk("reen_joy", {8'd0, joy}, 32'hFC9FFE);
      chk("reen_md", {30'd0, md}, 32'd2);

      // Reset mid-frame (select is low in step 6 here) returns everything at once
      chk("pre_rst_p7", {31'd0, joy_p7}, 32'd0);
      res_n = 1'b0;
      #1;
      chk("mrst_p7", {31'd0, joy_p7}, 32'd1);
      chk("mrst_joy", {8'd0, joy}, 32'hFFFFFF);
      chk("mrst_md", {30'd0, md}, 32'd0);
      chk("mrst_six", {30'd0, six_btn}, 32'd0);
      chk("mrst_done", {31'd0, frame_done}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
